// File: rtl/t_flip_flop_bank_if.sv
// Bus bundle for the T flip-flop bank: control inputs, flip-flop states,
// the per-bit toggle strobe, the prescaler tick and the prescaler count.
//
// Signalling: there is no valid/ready pairing. Every control input is
// sampled on each rising clk edge where ena=1. toggled and tick are
// single-cycle registered strobes: each is high for exactly the one cycle
// that follows the edge that produced it. count is a read-only view of the
// prescaler and has no side effects.
interface t_flip_flop_bank_if #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 4
);
    logic             ena;
    logic [1:0]       mode;
    logic [WIDTH-1:0] t_in;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [DIV_W-1:0] div_ratio;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] toggled;
    logic             tick;
    logic [DIV_W-1:0] count;

    modport master (
        output ena, mode, t_in, load, load_val, div_ratio,
        input  q, toggled, tick, count
    );

    modport slave (
        input  ena, mode, t_in, load, load_val, div_ratio,
        output q, toggled, tick, count
    );
endinterface

// File: rtl/t_flip_flop_bank.sv
// Bank of WIDTH toggle flip-flops with four run-time modes: level toggle,
// rising-edge toggle, prescaled toggle and a synchronous T-chain up-counter.
// Parallel load overrides every mode. toggled reports exactly the bits that
// a toggle flipped on the previous enabled edge.
module t_flip_flop_bank #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 4
) (
    input logic              clk,
    input logic              rst_n,
    t_flip_flop_bank_if.slave bus
);

    typedef enum logic [1:0] {
        MODE_LEVEL = 2'b00,
        MODE_EDGE  = 2'b01,
        MODE_DIV   = 2'b10,
        MODE_CHAIN = 2'b11
    } mode_e;

    mode_e            mode_sel;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] toggled_r;
    logic             tick_r;
    logic [DIV_W-1:0] cnt_r;
    logic [WIDTH-1:0] t_prev_r;

    logic [WIDTH-1:0] q_next;
    logic [DIV_W-1:0] cnt_next;
    logic             tick_next;
    logic [WIDTH-1:0] chain_en;
    logic             carry;

    assign mode_sel    = mode_e'(bus.mode);
    assign bus.q       = q_r;
    assign bus.toggled = toggled_r;
    assign bus.tick    = tick_r;
    assign bus.count   = cnt_r;

    // Ripple enable for the T-chain: bit i toggles when t_in[0] and all lower bits are one.
    always_comb begin
        chain_en = '0;
        carry    = bus.t_in[0];
        for (int i = 0; i < WIDTH; i++) begin
            chain_en[i] = carry;
            carry       = carry & q_r[i];
        end
    end

    // Mode decode: next flip-flop state, prescaler step and tick for a non-load edge.
    always_comb begin
        q_next    = q_r;
        cnt_next  = '0;
        tick_next = 1'b0;
        case (mode_sel)
            MODE_LEVEL: q_next = q_r ^ bus.t_in;
            MODE_EDGE:  q_next = q_r ^ (bus.t_in & ~t_prev_r);
            MODE_DIV: begin
                // A ratio lowered below the running count is not clamped:
                // the counter runs on to all-ones and wraps to 0 first.
                if (cnt_r == bus.div_ratio) begin
                    cnt_next  = '0;
                    tick_next = 1'b1;
                    q_next    = q_r ^ bus.t_in;
                end else begin
                    cnt_next = cnt_r + 1'b1;
                end
            end
            MODE_CHAIN: q_next = q_r ^ chain_en;
            default:    q_next = q_r;
        endcase
    end

    // State registers: load beats mode operation, ena=0 freezes state and clears the strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r       <= '0;
            toggled_r <= '0;
            tick_r    <= 1'b0;
            cnt_r     <= '0;
            t_prev_r  <= '0;
        end else if (bus.ena) begin
            // t_prev follows t_in in every mode so entering edge mode sees no stale edge.
            t_prev_r <= bus.t_in;
            if (bus.load) begin
                q_r       <= bus.load_val;
                toggled_r <= '0;
                tick_r    <= 1'b0;
                cnt_r     <= '0;
            end else begin
                q_r       <= q_next;
                toggled_r <= q_next ^ q_r;
                tick_r    <= tick_next;
                cnt_r     <= cnt_next;
            end
        end else begin
            toggled_r <= '0;
            tick_r    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_t_flip_flop_bank.sv
// Directed bench for t_flip_flop_bank (WIDTH=8, DIV_W=4). Inputs change 1ns
// after a rising edge and outputs are checked at the same point, so each
// step() applies one enabled edge to the values set beforehand.
module tb_t_flip_flop_bank;

    localparam int WIDTH = 8;
    localparam int DIV_W = 4;

    logic clk;
    logic rst_n;

    int vectors;
    int miscompares;

    t_flip_flop_bank_if #(.WIDTH(WIDTH), .DIV_W(DIV_W)) bus ();

    t_flip_flop_bank #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] q_exp,
                             input logic [7:0] tog_exp, input logic tick_exp);
        check({tag, ".q"},       32'(bus.q),       32'(q_exp));
        check({tag, ".toggled"}, 32'(bus.toggled), 32'(tog_exp));
        check({tag, ".tick"},    32'(bus.tick),    32'(tick_exp));
    endtask

    initial begin
        logic [7:0] q_exp;
        vectors     = 0;
        miscompares = 0;

        rst_n         = 1'b0;
        bus.ena       = 1'b0;
        bus.mode      = 2'b00;
        bus.t_in      = '0;
        bus.load      = 1'b0;
        bus.load_val  = '0;
        bus.div_ratio = '0;
        step();
        check_out("reset", 8'h00, 8'h00, 1'b0);
        check("reset.count", 32'(bus.count), 32'd0);
        rst_n = 1'b1;

        // Mode 00: t_in=0x0F for three edges from q=0
        bus.ena  = 1'b1;
        bus.t_in = 8'h0F;
        step(); check_out("lvl1", 8'h0F, 8'h0F, 1'b0);
        step(); check_out("lvl2", 8'h00, 8'h0F, 1'b0);
        step(); check_out("lvl3", 8'h0F, 8'h0F, 1'b0);

        // Load 0xA5 then hold, then asynchronous reset between edges
        bus.t_in     = 8'h00;
        bus.load     = 1'b1;
        bus.load_val = 8'hA5;
        step(); check_out("ldA5", 8'hA5, 8'h00, 1'b0);
        bus.load = 1'b0;
        step(); check_out("holdA5", 8'hA5, 8'h00, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_out("async_rst", 8'h00, 8'h00, 1'b0);
        check("async_rst.count", 32'(bus.count), 32'd0);
        step();
        rst_n = 1'b1;

        // Mode 01: t_in held at 0x01 for four edges, then released
        bus.mode = 2'b01;
        bus.t_in = 8'h01;
        step(); check_out("edge1", 8'h01, 8'h01, 1'b0);
        step(); check_out("edge2", 8'h01, 8'h00, 1'b0);
        step(); check_out("edge3", 8'h01, 8'h00, 1'b0);
        step(); check_out("edge4", 8'h01, 8'h00, 1'b0);
        bus.t_in = 8'h00;
        step(); check_out("edge_rel", 8'h01, 8'h00, 1'b0);

        // Mode 10: div_ratio=3, t_in=0xFF, twelve edges after a clearing load
        bus.mode      = 2'b10;
        bus.div_ratio = 4'd3;
        bus.t_in      = 8'hFF;
        bus.load      = 1'b1;
        bus.load_val  = 8'h00;
        step(); check_out("div_ld", 8'h00, 8'h00, 1'b0);
        bus.load = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            q_exp = (k < 4) ? 8'h00 : (k < 8) ? 8'hFF : (k < 12) ? 8'h00 : 8'hFF;
            check_out($sformatf("div%0d", k), q_exp, (k % 4 == 0) ? 8'hFF : 8'h00, (k % 4 == 0));
        end

        // Freeze mid-count with ena=0 for five edges
        step(); step();
        check("pre_freeze.count", 32'(bus.count), 32'd2);
        bus.ena = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            check_out($sformatf("frz%0d", k), 8'hFF, 8'h00, 1'b0);
            check($sformatf("frz%0d.count", k), 32'(bus.count), 32'd2);
        end
        bus.ena = 1'b1;
        step(); check_out("unfrz1", 8'hFF, 8'h00, 1'b0);
        step(); check_out("unfrz2", 8'h00, 8'hFF, 1'b1);

        // Ratio lowered below the running count: counter runs to 15, wraps, then matches
        bus.div_ratio = 4'd7;
        step(); step(); step();
        check("lower.count3", 32'(bus.count), 32'd3);
        bus.div_ratio = 4'd1;
        for (int k = 1; k <= 14; k++) begin
            step();
            check($sformatf("lower%0d.tick", k), 32'(bus.tick), 32'd0);
            if (k == 12) check("lower.count15", 32'(bus.count), 32'd15);
            if (k == 13) check("lower.wrap", 32'(bus.count), 32'd0);
        end
        step(); check_out("lower_tick", 8'hFF, 8'hFF, 1'b1);

        // div_ratio=0 ticks every edge and behaves as level mode
        bus.div_ratio = 4'd0;
        bus.t_in      = 8'h3C;
        step(); check_out("div0_a", 8'hC3, 8'h3C, 1'b1);
        step(); check_out("div0_b", 8'hFF, 8'h3C, 1'b1);

        // Leaving mode 10 clears the prescaler and tick
        bus.div_ratio = 4'd5;
        bus.t_in      = 8'h00;
        step(); step();
        check("mid.count", 32'(bus.count), 32'd2);
        bus.mode = 2'b00;
        step(); check_out("leave_div", 8'hFF, 8'h00, 1'b0);
        check("leave_div.count", 32'(bus.count), 32'd0);

        // Mode 11: load 0xFE, then count up through the wrap
        bus.mode     = 2'b11;
        bus.t_in     = 8'h01;
        bus.load     = 1'b1;
        bus.load_val = 8'hFE;
        step(); check_out("chain_ld", 8'hFE, 8'h00, 1'b0);
        bus.load = 1'b0;
        step(); check_out("chain1", 8'hFF, 8'h01, 1'b0);
        step(); check_out("chain2", 8'h00, 8'hFF, 1'b0);
        step(); check_out("chain3", 8'h01, 8'h01, 1'b0);
        bus.load     = 1'b1;
        bus.load_val = 8'h40;
        step(); check_out("chain_ldovr", 8'h40, 8'h00, 1'b0);
        bus.load = 1'b0;
        bus.t_in = 8'hFE;
        step(); check_out("chain_upper_ign", 8'h40, 8'h00, 1'b0);
        bus.t_in = 8'h03;
        step(); check_out("chain_inc", 8'h41, 8'h01, 1'b0);

        // Switch into mode 01 with t_in unchanged: no false edge
        bus.mode = 2'b01;
        step(); check_out("edge_switch", 8'h41, 8'h00, 1'b0);
        bus.t_in = 8'h07;
        step(); check_out("edge_bit2", 8'h45, 8'h04, 1'b0);

        // Load together with a toggle request: load wins
        bus.mode     = 2'b00;
        bus.t_in     = 8'hFF;
        bus.load     = 1'b1;
        bus.load_val = 8'h12;
        step(); check_out("ld_vs_tog", 8'h12, 8'h00, 1'b0);
        bus.load = 1'b0;
        step(); check_out("post_ld", 8'hED, 8'hFF, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/t_flip_flop_bank.md
Name: t_flip_flop_bank

Overview:
- Parametrised successor to the single T flip-flop user project: a bank of WIDTH toggle flip-flops sharing one clock.
- Four run-time selectable modes: level toggle, edge toggle, prescaled (divider) toggle, and synchronous T-chain counter.
- Supports parallel load and a per-bit "toggled" strobe.
- Instantiated inside the top-level user project; ui_in/uio_in are mapped onto its inputs and q onto uo_out.

Parameters:
- WIDTH, 8, number of T flip-flop channels (1..32).
- DIV_W, 4, width of the prescaler counter and div_ratio input.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  block enable; 0 freezes all state.
- mode  input  2  00 level, 01 edge, 10 divider, 11 chain counter.
- t_in  input  WIDTH  per-channel toggle request / enable (mode 11 uses t_in[0] only).
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value written to q on load.
- div_ratio  input  DIV_W  divider terminal count for mode 10.
- q  output  WIDTH  flip-flop states.
- toggled  output  WIDTH  registered strobe: bit i = 1 for one cycle after q[i] changed by a toggle.
- tick  output  1  registered prescaler terminal-count strobe (mode 10 only).

Behaviour:
Reset
- Reset is asynchronous on rst_n low, released synchronously by design use.
- Under reset: q=0, toggled=0, tick=0, prescaler count=0, t_prev=0.

Enable
- ena=0: q, prescaler and t_prev hold; toggled=0 and tick=0 on the next edge.

Priority per enabled edge
- Priority order: load > mode operation.
- load=1: q<=load_val, toggled<=0, tick<=0, prescaler<=0, and t_prev<=t_in.

Edge register and latency
- t_prev<=t_in on every enabled edge in all modes, so a mode switch into 01 creates no false edge.
- After reset, t_prev=0, so a t_in bit already high counts as an edge on the first enabled cycle.
- Latency: inputs are sampled at edge k; q, toggled and tick reflect them after edge k (one cycle).

Modes
- Mode 00 (level): q[i]<=q[i]^t_in[i] every enabled edge.
- Mode 01 (edge): q[i]<=q[i]^(t_in[i]&~t_prev[i]); only rising edges of t_in toggle.
- Mode 10 (divider):
  - The prescaler counts 0..div_ratio.
  - On an edge with count==div_ratio: count<=0, tick<=1, q[i]<=q[i]^t_in[i].
  - Otherwise: count<=count+1, tick<=0, q holds.
  - div_ratio=0 gives a tick every cycle, making the mode equivalent to mode 00.
  - If div_ratio is lowered below the current count: the counter continues to all-ones, wraps to 0, then compares normally. No mid-run clamp.
- Mode 11 (chain counter):
  - Bit i toggles when t_in[0] & (&q[i-1:0]); bit 0 toggles when t_in[0].
  - This makes q a synchronous up-counter by 1.
  - At all-ones q wraps to 0 and toggled=all-ones.
  - t_in[WIDTH-1:1] are ignored.

Prescaler and outputs
- Prescaler is held at 0 and tick=0 whenever mode!=10. Entering mode 10 starts from count 0.
- toggled<=q_next^q on every enabled non-load edge (exactly the flipped bits).
- Simultaneous load and a toggle request: load wins; no toggle, no strobe.

Mid-operation changes
- Reset mid-count: all state returns to reset values immediately, with no residual tick or toggled pulse.
- mode changes take effect on the edge where the new value is sampled. No pipeline flush is required beyond the prescaler clear.

Test Plan:
- Reset with q previously 0xA5 in mode 00 -> q=0x00, toggled=0x00, tick=0 immediately on rst_n low, asynchronously (no clock edge needed).
- Mode 00, t_in=0x0F for 3 cycles from q=0 -> q sequence 0x0F, 0x00, 0x0F; toggled=0x0F each cycle.
- Mode 01, t_in held at 0x01 for 4 cycles then released -> q[0] toggles once only (q=0x01); toggled[0] pulses for a single cycle.
- Mode 10, div_ratio=3, t_in=0xFF, 12 cycles -> tick high on cycles 4, 8 and 12; q alternates 0xFF/0x00/0xFF at those cycles; q holds otherwise.
- Mode 11, t_in[0]=1, load 0xFE then 3 cycles -> q=0xFF, 0x00 (toggled=0xFF), 0x01; load during a count overrides the increment.
- ena=0 for 5 cycles in mode 10 mid-count -> q and the prescaler count are frozen; on re-enable, tick occurs exactly div_ratio+1 counts after the previous tick, ignoring the paused cycles.
